mem_uart_initiator: RTL and testbench
=====================================

# mem_uart_initiator

CPU-side initiator for the UART memory link: turns single-word read/write requests from the core's memory port into 72-bit channel messages for the multichannel transceiver and returns read data from the response message. It is the counterpart of the simulation memory responder on the far end of the link. It sits between the CPU memory controller and `multichan_trans` (channel 0). It handles one transaction at a time, with a response timeout and a counter for unsolicited responses.

## Interface
- TIMEOUT, 100000: cycles to wait for a read response in WAIT_RESP; 0 disables the timeout.
- clk  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address, passed through unmodified.
- req_wdata  in  32  write data; byte 0 in [7:0].
- req_mask  in  4  byte enables; bit i enables byte i.
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_err  out  1  qualified by resp_valid; 1 = timeout or malformed response.
- resp_rdata  out  32  read data, qualified by resp_valid; 0 for writes and errors.
- tx_flag  out  1  one-cycle push of {tx_length, tx_data} into the transceiver.
- tx_length  out  5  message length in bytes.
- tx_data  out  72  message payload.
- tx_writable  in  1  transceiver can accept a message.
- rx_flag  out  1  one-cycle pop of the received message.
- rx_length  in  5  received message length.
- rx_data  in  72  received payload.
- rx_readable  in  1  a received message is present.
- drop_cnt  out  8  saturating count of discarded unsolicited messages.

## Operation
- Message formats:
  - Read request: tx_length=5; tx_data[31:0]=addr; tx_data[71:32]=0 (bit 32 = 0 marks a read).
  - Write request: tx_length=9; [31:0]=wdata, [63:32]=addr, [67:64]=mask, [71:68]=0.
  - Read response: length 4; data in [31:0].
- States: IDLE, SEND, WAIT_RESP. All outputs except req_ready are registered.
- IDLE:
  - On accept, latch we/addr/wdata/mask and go to SEND.
  - If rx_readable && !rx_flag, pop the message (rx_flag<=1), discard it, and increment drop_cnt (saturates at 255).
- SEND: on an edge with tx_writable=1, set tx_flag<=1 and load tx_length/tx_data.
  - Write: go to IDLE; resp_valid<=1, resp_err<=0, resp_rdata<=0 on the same edge.
  - Read: go to WAIT_RESP and clear the timeout counter.
  - tx_writable=0: hold in SEND indefinitely; no timeout applies.
- WAIT_RESP:
  - rx_readable && !rx_flag: rx_flag<=1, resp_valid<=1, resp_rdata<=rx_data[31:0], resp_err<=(rx_length!=4); go to IDLE.
  - Otherwise, if TIMEOUT!=0 && cnt==TIMEOUT-1: resp_valid<=1, resp_err<=1, resp_rdata<=0; go to IDLE.
  - Otherwise cnt<=cnt+1.
  - A message present on the timeout edge wins over the timeout.
- Never pop on two consecutive cycles: the !rx_flag guard gives the transceiver one cycle to update rx_readable.
- A response arriving after a timeout reaches IDLE and is counted in drop_cnt.
- req_mask=0 is legal: the write is sent unchanged.

## Timing
- Reset:
  - state=IDLE.
  - tx_flag, rx_flag, resp_valid, resp_err = 0.
  - resp_rdata, tx_length, tx_data, drop_cnt, cnt = 0.
  - Reset mid-transaction abandons it with no resp_valid; its late response is dropped and counted.
- Edge E0 is the accept edge. With tx_writable=1:
  - SEND fires at E1.
  - tx_flag is high from E1 to E2.
  - A write's resp_valid is high from E1 to E2 as well (2-edge write latency).
- Read: the response is sampled at edge En ≥ E2; resp_valid and rx_flag are high from En to En+1.
  - Earliest read completion is at E2 if rx_readable is already high then.
- Timeout: resp_valid rises on the TIMEOUT-th edge spent in WAIT_RESP.
- req_ready is low from E0 until the edge that returns to IDLE. A new request can be accepted on the edge after resp_valid rises.
- resp_valid, tx_flag and rx_flag are never high for more than one consecutive cycle, except back-to-back discards separated by the guard cycle.

## Test plan
- Read: addr=0x1000, tx_writable=1; rx_readable raised 5 cycles later with length 4, data 0xDEADBEEF -> one tx_flag pulse with length 5, data[31:0]=0x1000, data[32]=0; resp_valid pulse with rdata=0xDEADBEEF, err=0; exactly one rx_flag pulse.
- Write: addr=0x104, wdata=0x41, mask=4'b0001 -> tx_length=9, tx_data=72'h01_00000104_00000041; resp_valid in the same cycle as tx_flag.
- Backpressure: tx_writable low for 10 cycles -> state stays SEND, no tx_flag, req_ready=0; tx_writable raised -> send on the next edge.
- Timeout with TIMEOUT=8 and no response -> resp_err=1, rdata=0 on the 8th WAIT_RESP edge. Response delivered afterwards -> dropped, drop_cnt=1.
- Malformed response (length 9) -> resp_err=1, rdata=data[31:0]. Response and timeout coinciding on the same edge -> response wins, err=0.
- RST asserted in WAIT_RESP -> all outputs 0 on the next edge; a subsequent unsolicited message -> one rx_flag pulse, drop_cnt=1. Feed 300 unsolicited messages -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/mem_uart_initiator_if.sv
// Request/response, transmit and receive signals of the UART memory-link initiator.
interface mem_uart_initiator_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        tx_flag;
  logic [4:0]  tx_length;
  logic [71:0] tx_data;
  logic        tx_writable;
  logic        rx_flag;
  logic [4:0]  rx_length;
  logic [71:0] rx_data;
  logic        rx_readable;
  logic [7:0]  drop_cnt;

  // Initiator side
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    input  tx_writable, rx_length, rx_data, rx_readable,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output tx_flag, tx_length, tx_data, rx_flag, drop_cnt
  );

  // Core memory port and transceiver side
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    output tx_writable, rx_length, rx_data, rx_readable,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  tx_flag, tx_length, tx_data, rx_flag, drop_cnt
  );
endinterface

// File: rtl/mem_uart_initiator.sv
// Single-outstanding memory initiator: packs read/write requests into channel
// messages, waits for read responses with a timeout, drops unsolicited messages.
module mem_uart_initiator #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 RST,
  mem_uart_initiator_if.master bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned MSG_W  = 72;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DROP_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                tx_flag_q, tx_flag_d;
  logic [LEN_W-1:0]    tx_length_q, tx_length_d;
  logic [MSG_W-1:0]    tx_data_q, tx_data_d;
  logic                rx_flag_q, rx_flag_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rx_take_c;

  // A message may be popped only if we did not pop on the previous cycle
  assign rx_take_c = bus.rx_readable && !rx_flag_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    tx_flag_d    = 1'b0;
    tx_length_d  = tx_length_q;
    tx_data_d    = tx_data_q;
    rx_flag_d    = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    drop_cnt_d   = drop_cnt_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          mask_d  = bus.req_mask;
          state_d = SEND;
        end
        if (rx_take_c) begin
          rx_flag_d = 1'b1;
          if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end
      SEND: begin
        if (bus.tx_writable) begin
          tx_flag_d = 1'b1;
          if (we_q) begin
            tx_length_d  = LEN_W'(9);
            tx_data_d    = {4'b0000, mask_q, addr_q, wdata_q};
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
            state_d      = IDLE;
          end else begin
            tx_length_d = LEN_W'(5);
            tx_data_d   = {40'd0, addr_q};
            cnt_d       = '0;
            state_d     = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (rx_take_c) begin
          rx_flag_d    = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus.rx_data[DATA_W-1:0];
          resp_err_d   = (bus.rx_length != LEN_W'(4));
          state_d      = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      tx_flag_q    <= 1'b0;
      tx_length_q  <= '0;
      tx_data_q    <= '0;
      rx_flag_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      drop_cnt_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      tx_flag_q    <= tx_flag_d;
      tx_length_q  <= tx_length_d;
      tx_data_q    <= tx_data_d;
      rx_flag_q    <= rx_flag_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      drop_cnt_q   <= drop_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.tx_flag    = tx_flag_q;
  assign bus.tx_length  = tx_length_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.rx_flag    = rx_flag_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_mem_uart_initiator.sv
// Testbench for mem_uart_initiator with an 8-cycle response timeout.
module tb_mem_uart_initiator;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic RST = 1'b1;
  mem_uart_initiator_if ifc ();

  mem_uart_initiator #(.TIMEOUT(TMO)) dut (.clk(clk), .RST(RST), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  len;
    logic [71:0] data;
  } rx_msg_t;

  rx_msg_t rxq[$];
  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  bit dbl = 0;
  bit prev_tx = 0, prev_rx = 0, prev_rv = 0;

  // Transceiver receive side: the head of the queue is presented until popped
  task automatic refresh_rx();
    if (rxq.size() > 0) begin
      ifc.rx_readable = 1'b1;
      ifc.rx_length   = rxq[0].len;
      ifc.rx_data     = rxq[0].data;
    end else begin
      ifc.rx_readable = 1'b0;
      ifc.rx_length   = '0;
      ifc.rx_data     = '0;
    end
  endtask

  task automatic push_rx(input logic [4:0] len, input logic [71:0] data);
    rx_msg_t m;
    m.len  = len;
    m.data = data;
    rxq.push_back(m);
    refresh_rx();
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    rx_msg_t m;
    @(posedge clk);
    #1;
    if (ifc.rx_flag) begin
      if (rxq.size() > 0) m = rxq.pop_front();
      pops++;
    end
    if ((ifc.tx_flag && prev_tx) || (ifc.rx_flag && prev_rx) || (ifc.resp_valid && prev_rv)) dbl = 1;
    prev_tx = ifc.tx_flag;
    prev_rx = ifc.rx_flag;
    prev_rv = ifc.resp_valid;
    refresh_rx();
  endtask

  // Present a request once req_ready is seen; returns after the accept edge
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ifc.req_ready; i++) step();
    if (!ifc.req_ready) return;
    ifc.req_valid = 1'b1;
    ifc.req_we    = we;
    ifc.req_addr  = a;
    ifc.req_wdata = d;
    ifc.req_mask  = m;
    step();
    ifc.req_valid = 1'b0;
    ok = 1;
  endtask

  // Message the transceiver should receive for a request
  function automatic logic [76:0] exp_msg(input logic we, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] m);
    logic [71:0] p;
    p = '0;
    if (we) begin
      p[31:0]  = d;
      p[63:32] = a;
      p[67:64] = m;
      return {5'd9, p};
    end
    p[31:0] = a;
    return {5'd5, p};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    vectors++;
    if ({ifc.tx_flag, ifc.rx_flag, ifc.resp_valid, ifc.resp_err, ifc.resp_rdata,
         ifc.tx_length, ifc.tx_data, ifc.drop_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {ifc.tx_flag, ifc.rx_flag, ifc.resp_valid,
               ifc.resp_err, ifc.resp_rdata, ifc.tx_length, ifc.tx_data, ifc.drop_cnt});
    end
    vectors++;
    if (ifc.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", ifc.req_ready);
    end
    RST = 1'b0;
  endtask

  task automatic test_read();
    bit ok;
    bit early;
    int p0;
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, ok);
    step();
    vectors++;
    if (!ok || {ifc.tx_flag, ifc.tx_length, ifc.tx_data} !== {1'b1, exp_msg(1'b0, 32'h1000, 32'h0, 4'h0)}) begin
      miscompares++;
      $display("FAIL read_tx: got %b %0d %h want 1 5 %h", ifc.tx_flag, ifc.tx_length, ifc.tx_data, 72'h1000);
    end
    early = 0;
    repeat (4) begin
      step();
      if (ifc.resp_valid || ifc.rx_flag) early = 1;
    end
    p0 = pops;
    push_rx(5'd4, 72'hDEADBEEF);
    step();
    vectors++;
    if (early || {ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, ifc.rx_flag} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b1}) begin
      miscompares++;
      $display("FAIL read_resp: got v=%b e=%b d=%h rx=%b early=%b want 1 0 deadbeef 1 0",
               ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, ifc.rx_flag, early);
    end
    step();
    step();
    vectors++;
    if (pops - p0 != 1 || ifc.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_one_pop: got pops=%0d v=%b want 1 0", pops - p0, ifc.resp_valid);
    end
  endtask

  task automatic test_write();
    bit ok;
    do_req(1'b1, 32'h104, 32'h41, 4'b0001, ok);
    step();
    vectors++;
    if (!ok || ifc.tx_flag !== 1'b1 || ifc.tx_length !== 5'd9 || ifc.tx_data !== 72'h01_00000104_00000041) begin
      miscompares++;
      $display("FAIL write_tx: got %b %0d %h want 1 9 010000010400000041", ifc.tx_flag, ifc.tx_length, ifc.tx_data);
    end
    vectors++;
    if ({ifc.resp_valid, ifc.resp_err, ifc.resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL write_resp: got v=%b e=%b d=%h want 1 0 0", ifc.resp_valid, ifc.resp_err, ifc.resp_rdata);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    ifc.tx_writable = 1'b0;
    do_req(1'b1, 32'hA0, 32'h1234_5678, 4'b0000, ok);
    bad = !ok;
    repeat (10) begin
      step();
      if (ifc.tx_flag || ifc.req_ready || ifc.resp_valid) bad = 1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL bp_hold: got activity while blocked, want none");
    end
    ifc.tx_writable = 1'b1;
    step();
    vectors++;
    if ({ifc.tx_flag, ifc.resp_valid, ifc.tx_length, ifc.tx_data} !==
        {1'b1, 1'b1, exp_msg(1'b1, 32'hA0, 32'h1234_5678, 4'b0000)}) begin
      miscompares++;
      $display("FAIL bp_release: got tx=%b v=%b %0d %h", ifc.tx_flag, ifc.resp_valid, ifc.tx_length, ifc.tx_data);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    logic [7:0] d0;
    do_req(1'b0, 32'h2000, 32'h0, 4'h0, ok);
    step();
    early = !ok || !ifc.tx_flag;
    repeat (TMO - 1) begin
      step();
      if (ifc.resp_valid) early = 1;
    end
    step();
    vectors++;
    if (early || {ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, ifc.req_ready} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout: got v=%b e=%b d=%h rdy=%b early=%b want 1 1 0 1 0",
               ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, ifc.req_ready, early);
    end
    d0 = ifc.drop_cnt;
    push_rx(5'd4, 72'h55AA);
    step();
    vectors++;
    if (ifc.rx_flag !== 1'b1 || ifc.drop_cnt !== d0 + 8'd1 || ifc.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL late_drop: got rx=%b cnt=%0d v=%b want 1 %0d 0", ifc.rx_flag, ifc.drop_cnt, ifc.resp_valid, d0 + 8'd1);
    end
  endtask

  task automatic test_malformed();
    bit ok;
    logic [71:0] v;
    v = {8'($urandom), $urandom, $urandom};
    do_req(1'b0, 32'h3000, 32'h0, 4'h0, ok);
    step();
    step();
    push_rx(5'd9, v);
    step();
    vectors++;
    if (!ok || {ifc.resp_valid, ifc.resp_err, ifc.resp_rdata} !== {1'b1, 1'b1, v[31:0]}) begin
      miscompares++;
      $display("FAIL malformed: got v=%b e=%b d=%h want 1 1 %h", ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, v[31:0]);
    end
    step();
  endtask

  task automatic test_coincide();
    bit ok;
    do_req(1'b0, 32'h4000, 32'h0, 4'h0, ok);
    step();
    repeat (TMO - 1) step();
    push_rx(5'd4, 72'hC0FFEE01);
    step();
    vectors++;
    if (!ok || {ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, ifc.rx_flag} !== {1'b1, 1'b0, 32'hC0FFEE01, 1'b1}) begin
      miscompares++;
      $display("FAIL coincide: got v=%b e=%b d=%h rx=%b want 1 0 c0ffee01 1",
               ifc.resp_valid, ifc.resp_err, ifc.resp_rdata, ifc.rx_flag);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_req(1'b1, 32'h10, 32'hAAAA_0001, 4'hF, ok);
    step();
    vectors++;
    if (!ok || ifc.resp_valid !== 1'b1 || ifc.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: got v=%b rdy=%b want 1 1", ifc.resp_valid, ifc.req_ready);
    end
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b1;
    ifc.req_addr  = 32'h14;
    ifc.req_wdata = 32'hBBBB_0002;
    ifc.req_mask  = 4'h3;
    step();
    ifc.req_valid = 1'b0;
    step();
    vectors++;
    if ({ifc.tx_flag, ifc.resp_valid, ifc.tx_length, ifc.tx_data} !==
        {1'b1, 1'b1, exp_msg(1'b1, 32'h14, 32'hBBBB_0002, 4'h3)}) begin
      miscompares++;
      $display("FAIL b2b_second: got tx=%b v=%b %0d %h", ifc.tx_flag, ifc.resp_valid, ifc.tx_length, ifc.tx_data);
    end
  endtask

  task automatic test_random();
    bit ok, seen, wr_edge, bad;
    logic we;
    logic [31:0] a, d;
    logic [3:0] m;
    logic [4:0] len;
    logic [71:0] v;
    int dly;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      m = 4'($urandom);
      do_req(we, a, d, m, ok);
      seen = 0;
      wr_edge = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        ifc.tx_writable = 1'($urandom_range(0, 1));
        wr_edge = ifc.tx_writable;
        step();
        seen = ifc.tx_flag;
      end
      ifc.tx_writable = 1'b1;
      vectors++;
      if (!ok || !seen || !wr_edge || {ifc.tx_length, ifc.tx_data} !== exp_msg(we, a, d, m)) begin
        miscompares++;
        $display("FAIL rand_tx[%0d]: got ok=%b seen=%b wr=%b %0d %h want %h", n, ok, seen, wr_edge,
                 ifc.tx_length, ifc.tx_data, exp_msg(we, a, d, m));
      end
      if (we) begin
        vectors++;
        if ({ifc.resp_valid, ifc.resp_err, ifc.resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
          miscompares++;
          $display("FAIL rand_wresp[%0d]: got v=%b e=%b d=%h want 1 0 0", n, ifc.resp_valid, ifc.resp_err, ifc.resp_rdata);
        end
      end else begin
        dly = $urandom_range(0, 5);
        bad = 0;
        repeat (dly) begin
          step();
          if (ifc.resp_valid) bad = 1;
        end
        len = ($urandom_range(0, 3) == 0) ? 5'd9 : 5'd4;
        v = {8'($urandom), $urandom, $urandom};
        push_rx(len, v);
        step();
        vectors++;
        if (bad || {ifc.resp_valid, ifc.rx_flag, ifc.resp_err, ifc.resp_rdata} !==
            {1'b1, 1'b1, (len != 5'd4), v[31:0]}) begin
          miscompares++;
          $display("FAIL rand_rresp[%0d]: got v=%b rx=%b e=%b d=%h want 1 1 %b %h", n, ifc.resp_valid,
                   ifc.rx_flag, ifc.resp_err, ifc.resp_rdata, (len != 5'd4), v[31:0]);
        end
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int p0;
    do_req(1'b0, 32'h5000, 32'h0, 4'h0, ok);
    step();
    step();
    step();
    RST = 1'b1;
    step();
    vectors++;
    if (!ok || {ifc.tx_flag, ifc.rx_flag, ifc.resp_valid, ifc.resp_err, ifc.resp_rdata,
                ifc.tx_length, ifc.tx_data, ifc.drop_cnt} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got nonzero outputs (tx_len=%0d tx_data=%h)", ifc.tx_length, ifc.tx_data);
    end
    RST = 1'b0;
    p0 = pops;
    push_rx(5'd4, 72'h77);
    step();
    step();
    step();
    vectors++;
    if (pops - p0 != 1 || ifc.drop_cnt !== 8'd1 || ifc.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_drop: got pops=%0d cnt=%0d v=%b want 1 1 0", pops - p0, ifc.drop_cnt, ifc.resp_valid);
    end
    p0 = pops;
    for (int i = 0; i < 300; i++) push_rx(5'd4, 72'(i));
    for (int i = 0; i < 800 && rxq.size() > 0; i++) step();
    step();
    vectors++;
    if (rxq.size() != 0 || pops - p0 != 300 || ifc.drop_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL drop_saturate: got left=%0d pops=%0d cnt=%0d want 0 300 255", rxq.size(), pops - p0, ifc.drop_cnt);
    end
  endtask

  task automatic test_pulse_rules();
    vectors++;
    if (dbl) begin
      miscompares++;
      $display("FAIL single_pulse: got a pulse lasting two cycles, want none");
    end
  endtask

  initial begin
    ifc.req_valid   = 1'b0;
    ifc.req_we      = 1'b0;
    ifc.req_addr    = '0;
    ifc.req_wdata   = '0;
    ifc.req_mask    = '0;
    ifc.tx_writable = 1'b1;
    refresh_rx();
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_timeout();
    test_malformed();
    test_coincide();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_pulse_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
